// File: rtl/vedic_nxn_mul_pipe.sv
// rtl/vedic_nxn_mul_pipe.sv - pipelined Urdhva-Tiryagbhyam WIDTH x WIDTH multiplier with A/B stream join
// Held operands join into an operand stage, then one registered Vedic combine level per stage.
module vedic_nxn_mul_pipe #(
  parameter int WIDTH  = 8,
  parameter int SIGNED = 0,
  parameter int USER_W = 4
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic [WIDTH-1:0]     s_a_tdata,
  input  logic [USER_W-1:0]    s_a_tuser,
  input  logic                 s_a_tvalid,
  output logic                 s_a_tready,
  input  logic [WIDTH-1:0]     s_b_tdata,
  input  logic                 s_b_tvalid,
  output logic                 s_b_tready,
  output logic [2*WIDTH-1:0]   m_result_tdata,
  output logic [USER_W-1:0]    m_tuser,
  output logic                 m_tvalid,
  input  logic                 m_tready
);
  localparam int L = $clog2(WIDTH);

  logic              w_en;
  logic              w_join;
  logic              w_a_hs;
  logic              w_b_hs;
  logic              w_sgn;
  logic              r_a_held;
  logic              r_b_held;
  logic [WIDTH-1:0]  r_a_data;
  logic [WIDTH-1:0]  r_b_data;
  logic [USER_W-1:0] r_a_user;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [L:0]        r_vld;
  logic [L-1:0]      r_sgn;
  logic [USER_W-1:0] r_user [L+1];

  function automatic logic [3:0] f_vedic2x2(input logic [1:0] a, input logic [1:0] b);
    logic c1;
    c1 = a[1] & b[0] & a[0] & b[1];
    return {a[1] & b[1] & c1, (a[1] & b[1]) ^ c1, (a[1] & b[0]) ^ (a[0] & b[1]), a[0] & b[0]};
  endfunction

  // -2^(WIDTH-1) maps to 2^(WIDTH-1), which still fits WIDTH unsigned bits
  function automatic logic [WIDTH-1:0] f_mag(input logic [WIDTH-1:0] x);
    return (SIGNED != 0 && x[WIDTH-1]) ? -x : x;
  endfunction

  assign w_en       = !r_vld[L] || m_tready;
  assign w_join     = r_a_held && r_b_held && w_en;
  assign s_a_tready = !arst_n && (!r_a_held || w_join);
  assign s_b_tready = !arst_n && (!r_b_held || w_join);
  assign w_a_hs     = s_a_tvalid && s_a_tready;
  assign w_b_hs     = s_b_tvalid && s_b_tready;
  assign w_sgn      = (SIGNED != 0) && (r_a_data[WIDTH-1] ^ r_b_data[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (arst_n) begin
      r_a_held <= 1'b0;
      r_b_held <= 1'b0;
    end else begin
      if (w_a_hs) begin
        r_a_held <= 1'b1;
        r_a_data <= s_a_tdata;
        r_a_user <= s_a_tuser;
      end else if (w_join) begin
        r_a_held <= 1'b0;
      end
      if (w_b_hs) begin
        r_b_held <= 1'b1;
        r_b_data <= s_b_tdata;
      end else if (w_join) begin
        r_b_held <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_join) begin
      r_op_a <= f_mag(r_a_data);
      r_op_b <= f_mag(r_b_data);
    end
  end

  always_ff @(posedge clk) begin
    if (arst_n) begin
      r_vld <= '0;
      r_sgn <= '0;
      for (int k = 0; k <= L; k++) r_user[k] <= '0;
    end else if (w_en) begin
      r_vld[0]  <= w_join;
      r_sgn[0]  <= w_sgn;
      r_user[0] <= r_a_user;
      for (int k = 1; k <= L; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_user[k] <= r_user[k-1];
      end
      for (int k = 1; k < L; k++) r_sgn[k] <= r_sgn[k-1];
    end
  end

  // Level k holds every (block i of A) x (block j of B) product of 2^k-bit blocks
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int S   = 1 << k;
    localparam int S2  = 2 * S;
    localparam int H   = S / 2;
    localparam int N   = WIDTH / S;
    localparam bit NEG = (k == L) && (SIGNED != 0);

    logic [S2-1:0] w_pp [N*N];
    logic [S2-1:0] r_pp [N*N];

    for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
        if (k == 1) begin : g_leaf
          assign w_pp[i*N+j] = f_vedic2x2(r_op_a[2*i +: 2], r_op_b[2*j +: 2]);
        end else begin : g_comb
          localparam int NP = 2 * N;
          logic [S-1:0] w_ll;
          logic [S-1:0] w_lh;
          logic [S-1:0] w_hl;
          logic [S-1:0] w_hh;
          assign w_ll = g_lvl[k-1].r_pp[(2*i)*NP + 2*j];
          assign w_lh = g_lvl[k-1].r_pp[(2*i)*NP + 2*j + 1];
          assign w_hl = g_lvl[k-1].r_pp[(2*i+1)*NP + 2*j];
          assign w_hh = g_lvl[k-1].r_pp[(2*i+1)*NP + 2*j + 1];
          assign w_pp[i*N+j] = {w_hh, w_ll} + (S2'(w_hl) << H) + (S2'(w_lh) << H);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (arst_n) begin
        for (int x = 0; x < N*N; x++) r_pp[x] <= '0;
      end else if (w_en) begin
        for (int x = 0; x < N*N; x++) r_pp[x] <= (NEG && r_sgn[k-1]) ? -w_pp[x] : w_pp[x];
      end
    end
  end

  assign m_result_tdata = g_lvl[L].r_pp[0];
  assign m_tuser        = r_user[L];
  assign m_tvalid       = r_vld[L];
endmodule

// File: tb/tb_vedic_nxn_mul_pipe.sv
// tb/tb_vedic_nxn_mul_pipe.sv - directed self-checking bench for vedic_nxn_mul_pipe
// Four instances: 8-bit unsigned, 8-bit signed, 16-bit unsigned, 2-bit unsigned.
module tb_vedic_nxn_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] qat(input logic [63:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 64'hDEAD_BEEF_DEAD_BEEF;
  endfunction

  logic [7:0]  a8, b8;   logic [3:0] au8;  logic av8, bv8, ar8, br8, mv8, mr8;
  logic [15:0] md8;      logic [3:0] mu8;
  logic [7:0]  as_, bs;  logic [3:0] aus;  logic avs, bvs, ars, brs, mvs, mrs;
  logic [15:0] mds;      logic [3:0] mus;
  logic [15:0] a16, b16; logic [3:0] au16; logic av16, bv16, ar16, br16, mv16, mr16;
  logic [31:0] md16;     logic [3:0] mu16;
  logic [1:0]  a2, b2;   logic [3:0] au2;  logic av2, bv2, ar2, br2, mv2, mr2;
  logic [3:0]  md2;      logic [3:0] mu2;

  vedic_nxn_mul_pipe #(.WIDTH(8), .SIGNED(0), .USER_W(4)) u8 (
    .clk(clk), .arst_n(rst), .s_a_tdata(a8), .s_a_tuser(au8), .s_a_tvalid(av8), .s_a_tready(ar8),
    .s_b_tdata(b8), .s_b_tvalid(bv8), .s_b_tready(br8),
    .m_result_tdata(md8), .m_tuser(mu8), .m_tvalid(mv8), .m_tready(mr8));
  vedic_nxn_mul_pipe #(.WIDTH(8), .SIGNED(1), .USER_W(4)) us (
    .clk(clk), .arst_n(rst), .s_a_tdata(as_), .s_a_tuser(aus), .s_a_tvalid(avs), .s_a_tready(ars),
    .s_b_tdata(bs), .s_b_tvalid(bvs), .s_b_tready(brs),
    .m_result_tdata(mds), .m_tuser(mus), .m_tvalid(mvs), .m_tready(mrs));
  vedic_nxn_mul_pipe #(.WIDTH(16), .SIGNED(0), .USER_W(4)) u16 (
    .clk(clk), .arst_n(rst), .s_a_tdata(a16), .s_a_tuser(au16), .s_a_tvalid(av16), .s_a_tready(ar16),
    .s_b_tdata(b16), .s_b_tvalid(bv16), .s_b_tready(br16),
    .m_result_tdata(md16), .m_tuser(mu16), .m_tvalid(mv16), .m_tready(mr16));
  vedic_nxn_mul_pipe #(.WIDTH(2), .SIGNED(0), .USER_W(4)) u2 (
    .clk(clk), .arst_n(rst), .s_a_tdata(a2), .s_a_tuser(au2), .s_a_tvalid(av2), .s_a_tready(ar2),
    .s_b_tdata(b2), .s_b_tvalid(bv2), .s_b_tready(br2),
    .m_result_tdata(md2), .m_tuser(mu2), .m_tvalid(mv2), .m_tready(mr2));

  logic [63:0] q8[$], qs[$], q16[$], q2[$];
  logic        hold8 = 1'b0;
  logic [19:0] hold8_val;

  always @(negedge clk) begin
    if (hold8) check_eq("stall_hold", {mv8, mu8, md8}, {1'b1, hold8_val});
    hold8     = mv8 && !mr8;
    hold8_val = {mu8, md8};
    if (mv8 && mr8) q8.push_back({mu8, md8});
    if (mvs && mrs) qs.push_back({mus, mds});
    if (mv16 && mr16) q16.push_back({mu16, md16});
    if (mv2 && mr2) q2.push_back({mu2, md2});
  end

  logic [7:0]  bp_a [10] = '{8'h01, 8'h10, 8'h0F, 8'hFF, 8'h80, 8'hAA, 8'h12, 8'hFF, 8'h64, 8'hC8};
  logic [7:0]  bp_b [10] = '{8'h01, 8'h10, 8'h0F, 8'h01, 8'h02, 8'h02, 8'h34, 8'h00, 8'h64, 8'h03};
  logic [15:0] bp_p [10] = '{16'h0001, 16'h0100, 16'h00E1, 16'h00FF, 16'h0100,
                             16'h0154, 16'h03A8, 16'h0000, 16'h2710, 16'h0258};
  logic [7:0]  sg_a [4] = '{8'h80, 8'hFD, 8'h00, 8'h7F};
  logic [7:0]  sg_b [4] = '{8'h80, 8'h05, 8'hF9, 8'h80};
  logic [15:0] sg_p [4] = '{16'h4000, 16'hFFF1, 16'h0000, 16'hC080};
  logic [3:0]  w2_p [16] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3,
                             4'd0, 4'd2, 4'd4, 4'd6, 4'd0, 4'd3, 4'd6, 4'd9};

  int   lat, ia, ib, cyc;
  logic acc_a, acc_b, saw_low;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    {a8, b8, au8, av8, bv8} = '0;     mr8  = 1'b1;
    {as_, bs, aus, avs, bvs} = '0;    mrs  = 1'b1;
    {a16, b16, au16, av16, bv16} = '0; mr16 = 1'b1;
    {a2, b2, au2, av2, bv2} = '0;     mr2  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_tvalid", mv8, 1'b0);
    check_eq("rst_tdata", md8, 16'h0);
    check_eq("rst_tuser", mu8, 4'h0);
    check_eq("rst_readies", {ar8, br8}, 2'b00);
    @(posedge clk); #1 rst = 1'b0;

    // simultaneous operands, latency L+1
    a8 = 8'hFF; b8 = 8'hFF; au8 = 4'h5; av8 = 1'b1; bv8 = 1'b1;
    @(posedge clk); #1 av8 = 1'b0; bv8 = 1'b0;
    lat = 0;
    while (!mv8 && lat < 20) begin @(posedge clk); #1 lat++; end
    check_eq("lat8", lat, 4);
    check_eq("ff_x_ff", md8, 16'hFE01);
    check_eq("ff_tuser", mu8, 4'h5);
    repeat (3) @(posedge clk); #1 q8.delete();

    // operand skew: A waits 4 cycles for B, second A must not slip in
    a8 = 8'd13; au8 = 4'h2; av8 = 1'b1;
    @(posedge clk); #1 a8 = 8'd99; au8 = 4'h7;
    for (int c = 0; c < 4; c++) begin
      check_eq("skew_a_ready_low", ar8, 1'b0);
      @(posedge clk); #1;
    end
    b8 = 8'd11; bv8 = 1'b1;
    check_eq("skew_a_ready_preb", ar8, 1'b0);
    @(posedge clk); #1 bv8 = 1'b0;
    check_eq("skew_a_ready_join", ar8, 1'b1);
    av8 = 1'b0;
    for (int c = 0; c < 20 && q8.size() < 1; c++) @(posedge clk);
    repeat (5) @(posedge clk); #1;
    check_eq("skew_count", q8.size(), 1);
    check_eq("skew_result", qat(q8, 0), {4'h2, 16'h008F});
    q8.delete();

    // backpressure: 10 pairs, downstream stalled on cycles 5-9
    ia = 0; ib = 0; cyc = 0; saw_low = 1'b0;
    while ((ia < 10 || ib < 10) && cyc < 60) begin
      mr8 = !(cyc >= 5 && cyc <= 9);
      av8 = (ia < 10);
      if (ia < 10) begin a8 = bp_a[ia]; au8 = 4'(ia); end
      bv8 = (ib < 10);
      if (ib < 10) b8 = bp_b[ib];
      @(negedge clk);
      acc_a = av8 && ar8;
      acc_b = bv8 && br8;
      if ((ia < 10 && !ar8) || (ib < 10 && !br8)) saw_low = 1'b1;
      @(posedge clk); #1;
      if (acc_a) ia++;
      if (acc_b) ib++;
      cyc++;
    end
    av8 = 1'b0; bv8 = 1'b0; mr8 = 1'b1;
    check_eq("bp_all_sent", {ia[7:0], ib[7:0]}, {8'd10, 8'd10});
    check_eq("bp_ready_dropped", saw_low, 1'b1);
    for (int c = 0; c < 40 && q8.size() < 10; c++) @(posedge clk);
    repeat (5) @(posedge clk); #1;
    check_eq("bp_count", q8.size(), 10);
    for (int i = 0; i < 10; i++) check_eq("bp_result", qat(q8, i), {4'(i), bp_p[i]});

    // signed corners
    for (int i = 0; i < 4; i++) begin
      as_ = sg_a[i]; bs = sg_b[i]; aus = 4'(i); avs = 1'b1; bvs = 1'b1;
      @(negedge clk);
      check_eq("sgn_ready", {ars, brs}, 2'b11);
      @(posedge clk); #1;
    end
    avs = 1'b0; bvs = 1'b0;
    for (int c = 0; c < 20 && qs.size() < 4; c++) @(posedge clk);
    #1;
    check_eq("sgn_count", qs.size(), 4);
    for (int i = 0; i < 4; i++) check_eq("sgn_result", qat(qs, i), {4'(i), sg_p[i]});

    // reset with a stalled output, products in flight and a held A
    mr16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a16 = 16'(i + 3); b16 = 16'h0003; au16 = 4'(i + 1); av16 = 1'b1; bv16 = 1'b1;
      @(posedge clk); #1;
    end
    bv16 = 1'b0; a16 = 16'h1234; au16 = 4'hA;
    @(posedge clk); #1 av16 = 1'b0;
    for (int c = 0; c < 20 && !mv16; c++) begin @(posedge clk); #1; end
    check_eq("mid_output_full", mv16, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_readies", {ar16, br16}, 2'b00);
    @(posedge clk); #1;
    check_eq("mid_rst_tvalid", mv16, 1'b0);
    check_eq("mid_rst_tdata", md16, 32'h0);
    rst = 1'b0; mr16 = 1'b1;
    repeat (10) @(posedge clk); #1;
    check_eq("mid_no_stale", q16.size(), 0);
    a16 = 16'hFFFF; b16 = 16'h0002; au16 = 4'hC; av16 = 1'b1; bv16 = 1'b1;
    @(posedge clk); #1 av16 = 1'b0; bv16 = 1'b0;
    for (int c = 0; c < 20 && q16.size() < 1; c++) @(posedge clk);
    repeat (3) @(posedge clk); #1;
    check_eq("post_rst_count", q16.size(), 1);
    check_eq("post_rst_result", qat(q16, 0), {4'hC, 32'h0001FFFE});

    // degenerate width: latency and full sweep
    a2 = 2'd3; b2 = 2'd3; au2 = 4'h1; av2 = 1'b1; bv2 = 1'b1;
    @(posedge clk); #1 av2 = 1'b0; bv2 = 1'b0;
    lat = 0;
    while (!mv2 && lat < 20) begin @(posedge clk); #1 lat++; end
    check_eq("lat2", lat, 2);
    check_eq("w2_3x3", md2, 4'h9);
    repeat (3) @(posedge clk); #1 q2.delete();
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        a2 = 2'(x); b2 = 2'(y); au2 = 4'(x * 4 + y); av2 = 1'b1; bv2 = 1'b1;
        @(posedge clk); #1;
      end
    end
    av2 = 1'b0; bv2 = 1'b0;
    for (int c = 0; c < 20 && q2.size() < 16; c++) @(posedge clk);
    #1;
    check_eq("w2_count", q2.size(), 16);
    for (int i = 0; i < 16; i++) check_eq("w2_sweep", qat(q2, i), {4'(i), w2_p[i]});

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/vedic_nxn_mul_pipe.md
Name: vedic_nxn_mul_pipe

Overview:
- Parametrised, fully pipelined Vedic (Urdhva-Tiryagbhyam) multiplier for the matrix multiplier datapath. Next generation of the 2x2 Vedic cell.
- Operands A and B arrive on independent valid/ready streams and are joined internally. The WIDTH x WIDTH product passes through one registered Vedic combine level per stage.
- Optional signed mode and a sideband tag that travels with each product.
- Sustains one product per clock when the downstream is always ready.

Parameters:
- WIDTH, 8: operand width; power of two, 2..32.
- SIGNED, 0: 0 = unsigned operands; 1 = two's-complement operands and result.
- USER_W, 4: width of the sideband tag captured with operand A.

Ports:
- clk  input  1  clock; all logic on rising edge.
- arst_n  input  1  reset; synchronous and active-high.
- s_a_tdata  input  WIDTH  operand A.
- s_a_tuser  input  USER_W  tag captured with A.
- s_a_tvalid  input  1  A valid.
- s_a_tready  output  1  A ready.
- s_b_tdata  input  WIDTH  operand B.
- s_b_tvalid  input  1  B valid.
- s_b_tready  output  1  B ready.
- m_result_tdata  output  2*WIDTH  product.
- m_tuser  output  USER_W  tag of this product.
- m_tvalid  output  1  result valid.
- m_tready  input  1  downstream ready.

Behaviour:
- Reset (arst_n high at a rising edge):
  - Clears the A/B holding flags and every stage valid bit.
  - m_tvalid = 0, m_result_tdata = 0, m_tuser = 0.
  - s_a_tready and s_b_tready are forced 0 while arst_n is high.
  - In-flight data is discarded; no partial result is ever emitted.
- Definitions:
  - L = log2(WIDTH).
  - en = !m_tvalid || m_tready (global pipeline advance).
  - join = a_held && b_held && en.
- Operand capture:
  - One holding register per operand, with a held flag.
  - s_a_tready = !arst_n && (!a_held || join); s_b_tready likewise with b_held.
  - On an A handshake: A data and tuser are loaded and a_held is set, even if the same cycle drains the old A through join. B is handled identically.
  - A and B are fully independent. Either may arrive any number of cycles before the other. A second A is not accepted until the first has joined.
- Join / stage 0:
  - On join, stage-1 registers load from the held operands, the held flags clear (unless reloaded that cycle), and stage-1 valid is set.
  - If en is high but no join occurs, stage-1 valid clears (bubble).
- Vedic levels:
  - Level 1 forms all (WIDTH/2)^2 2x2 Vedic partial products.
  - Level k forms the 2^k x 2^k products from four 2^(k-1) x 2^(k-1) sub-products: middle terms summed and shifted by 2^(k-1), high term shifted by 2^k.
  - Each level is registered. Stage L output is the final product register feeding m_result_tdata.
  - Every stage advances only when en = 1. When en = 0 all stages, valids and tags hold.
- Latency:
  - m_tvalid rises L clock edges after the edge at which join fires.
  - With both operands presented together to an idle, unstalled pipe, m_tvalid is high L+1 edges after the input handshake edge.
  - WIDTH = 2: L = 1.
- Output:
  - m_result_tdata and m_tuser are stable while m_tvalid && !m_tready.
  - Results leave in input-pair order. Bubbles are not collapsed.
- Signed mode (SIGNED = 1):
  - At join, the magnitudes |A| and |B| are taken at WIDTH+1 bits internally (a (WIDTH/2+1)-bit correction, or equivalent) so that -2^(WIDTH-1) is exact.
  - The sign bit sign = A[msb]^B[msb] is piped alongside the data.
  - The final stage negates the product when sign = 1.
  - (-2^(W-1)) x (-2^(W-1)) = 2^(2W-2), which is exact in 2W bits.
  - Zero times a negative operand yields 0; -0 is never output.
- Unsigned mode (SIGNED = 0): plain WIDTH x WIDTH -> 2*WIDTH product; no overflow is possible.
- Throughput:
  - With m_tready held at 1 and both inputs valid every cycle, one result per clock.
  - s_*_tready stays high continuously.

Test Plan:
- Simultaneous operands, unsigned:
  - WIDTH=8, SIGNED=0, A=0xFF, B=0xFF, tuser=0x5 in one handshake -> m_tvalid 4 edges later (L+1), m_result_tdata=0xFE01, m_tuser=0x5.
- Operand skew:
  - WIDTH=8, A=13 presented 4 cycles before B=11 -> s_a_tready low from the cycle after A accepted until join, then high again; result 0x008F; a second A is not taken early.
- Signed corners:
  - WIDTH=8, SIGNED=1, pairs (-128,-128), (-3,5), (0,-7), (127,-128) -> 0x4000, 0xFFF1, 0x0000, 0xC080, in order.
- Backpressure:
  - 10 back-to-back random pairs, m_tready low for cycles 5-9 -> en low freezes the pipe; m_tvalid and data held stable; s_*_tready drop once the holds fill; all 10 products correct, in order, none duplicated.
- Reset mid-operation:
  - WIDTH=16, 3 products in flight plus a held A, assert arst_n for one cycle -> m_tvalid = 0 and readies = 0 during reset; after release no stale result appears and the next pair 0xFFFF x 0x0002 yields 0x0001FFFE.
- Degenerate width:
  - WIDTH=2, SIGNED=0, A=3, B=3 -> result 4'h9 at L=1 latency; sweep all 16 pairs -> exact match.
